// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and helpers, so the controller and the butterfly
// post-stage derive the same pipeline latency.
package ntt_pkg;

    localparam int DEF_LOGQ   = 64;
    localparam int DEF_LOGN   = 12;
    localparam int DELAY_MUL  = 5;
    localparam int DELAY_RED  = 4;
    localparam int DELAY_MM   = DELAY_MUL + DELAY_RED;
    localparam int DELAY_ADD  = 1;
    localparam int DELAY_DIV2 = 1;
    localparam int HALF_W     = 64;

    function automatic int btf_latency(input int d_mm, input int d_add,
                                       input int d_div2, input bit div2_en);
        return d_mm + d_add + (div2_en ? d_div2 : 0);
    endfunction

    // Modular halving x/2 mod q for odd q: odd x borrows one q before the shift.
    function automatic logic [HALF_W-1:0] mod_half(input logic [HALF_W-1:0] x,
                                                   input logic [HALF_W-1:0] q);
        logic [HALF_W:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
        return t[HALF_W:1];
    endfunction

endpackage

// File: rtl/btf_ct_post_if.sv
// Stream bundle between the NTT controller/modmul and the butterfly post-stage.
interface btf_ct_post_if #(
    parameter int LOGQ = ntt_pkg::DEF_LOGQ,
    parameter int LOGN = ntt_pkg::DEF_LOGN
);
    logic            in_valid;
    logic [LOGQ-1:0] in_a;
    logic [LOGN-1:0] in_idx;
    logic [LOGQ-1:0] mm_out;
    logic [LOGQ-1:0] q;
    logic            out_valid;
    logic [LOGQ-1:0] out_e;
    logic [LOGQ-1:0] out_o;
    logic [LOGN-1:0] out_idx;
    logic            idle;

    modport slave (
        input  in_valid, in_a, in_idx, mm_out, q,
        output out_valid, out_e, out_o, out_idx, idle
    );

    modport master (
        output in_valid, in_a, in_idx, mm_out, q,
        input  out_valid, out_e, out_o, out_idx, idle
    );
endinterface

// File: rtl/sr_delay.sv
// Width x depth shift register with a valid lane; both lanes clear on reset.
module sr_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
endmodule

// File: rtl/btf_ct_post.sv
// Cooley-Tukey butterfly post-stage: aligns a with the modmul product, emits
// (a+p) mod q and (a-p) mod q. Define BTF_DIV2_EN to append a modular halving stage.
module btf_ct_post
    import ntt_pkg::*;
#(
    parameter int LOGQ       = ntt_pkg::DEF_LOGQ,
    parameter int LOGN       = ntt_pkg::DEF_LOGN,
    parameter int DELAY_MM   = ntt_pkg::DELAY_MM,
    parameter int DELAY_ADD  = ntt_pkg::DELAY_ADD,
    parameter int DELAY_DIV2 = ntt_pkg::DELAY_DIV2
) (
    input  logic          clk,
    input  logic          rst,
    btf_ct_post_if.slave  bus
);
`ifdef BTF_DIV2_EN
    localparam bit DIV2_EN = 1'b1;
`else
    localparam bit DIV2_EN = 1'b0;
`endif
    localparam int L  = btf_latency(DELAY_MM, DELAY_ADD, DELAY_DIV2, DIV2_EN);
    localparam int CW = $clog2(L + 1);
    localparam int AW = LOGQ + LOGN;
    localparam int RW = 2 * LOGQ + LOGN;

    logic            w_al_valid;
    logic [AW-1:0]   w_al_data;
    logic [LOGQ-1:0] w_al_a;
    logic [LOGN-1:0] w_al_idx;
    logic [LOGQ:0]   w_s, w_sq, w_d;
    logic [LOGQ-1:0] w_e, w_o;
    logic            w_as_valid;
    logic [RW-1:0]   w_as_data;
    logic            w_fin_valid;
    logic [RW-1:0]   w_fin_data;
    logic [CW-1:0]   r_count, w_count_next;
    logic            r_idle;

    sr_delay #(.WIDTH(AW), .DEPTH(DELAY_MM)) u_align (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.in_valid),
        .i_data  ({bus.in_a, bus.in_idx}),
        .o_valid (w_al_valid),
        .o_data  (w_al_data)
    );

    assign w_al_a   = w_al_data[AW-1:LOGN];
    assign w_al_idx = w_al_data[LOGN-1:0];

    // One extra bit keeps the carry of a+p and the borrow of a-p.
    assign w_s  = {1'b0, w_al_a} + {1'b0, bus.mm_out};
    assign w_sq = w_s - {1'b0, bus.q};
    assign w_e  = (w_s >= {1'b0, bus.q}) ? w_sq[LOGQ-1:0] : w_s[LOGQ-1:0];
    assign w_d  = {1'b0, w_al_a} - {1'b0, bus.mm_out};
    assign w_o  = w_d[LOGQ] ? (w_d[LOGQ-1:0] + bus.q) : w_d[LOGQ-1:0];

    sr_delay #(.WIDTH(RW), .DEPTH(DELAY_ADD)) u_addsub (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_al_valid),
        .i_data  ({w_e, w_o, w_al_idx}),
        .o_valid (w_as_valid),
        .o_data  (w_as_data)
    );

`ifdef BTF_DIV2_EN
    logic [LOGQ-1:0] w_as_e, w_as_o, w_he, w_ho;

    assign w_as_e = w_as_data[RW-1 -: LOGQ];
    assign w_as_o = w_as_data[LOGN +: LOGQ];
    assign w_he   = LOGQ'(mod_half(HALF_W'(w_as_e), HALF_W'(bus.q)));
    assign w_ho   = LOGQ'(mod_half(HALF_W'(w_as_o), HALF_W'(bus.q)));

    sr_delay #(.WIDTH(RW), .DEPTH(DELAY_DIV2)) u_div2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_as_valid),
        .i_data  ({w_he, w_ho, w_as_data[LOGN-1:0]}),
        .o_valid (w_fin_valid),
        .o_data  (w_fin_data)
    );
`else
    assign w_fin_valid = w_as_valid;
    assign w_fin_data  = w_as_data;
`endif

    assign bus.out_valid = w_fin_valid;
    assign bus.out_e     = w_fin_data[RW-1 -: LOGQ];
    assign bus.out_o     = w_fin_data[LOGN +: LOGQ];
    assign bus.out_idx   = w_fin_data[LOGN-1:0];

    // Simultaneous entry and exit leave the count unchanged.
    always_comb begin
        w_count_next = r_count;
        if (bus.in_valid && !w_fin_valid && (r_count != CW'(L))) begin
            w_count_next = r_count + 1'b1;
        end else if (!bus.in_valid && w_fin_valid && (r_count != '0)) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_idle  <= 1'b1;
        end else begin
            r_count <= w_count_next;
            r_idle  <= (w_count_next == '0);
        end
    end

    assign bus.idle = r_idle;
endmodule
